// File: rtl/disp_pkg.sv
// Shared types and constants for the decimal display path (binary-to-BCD converter).
package disp_pkg;

  localparam int BIN_W   = 27;
  localparam int DIGITS  = 8;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] DEC_MAX = 27'd99_999_999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Largest value representable in n decimal digits, used for the overflow flag.
  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = disp_pkg::BIN_W,
  parameter int DIGITS = disp_pkg::DIGITS
);
  // Handshake: start is a request taken only on an edge where busy=0; there is no
  // back-pressure and nothing is queued. done pulses one cycle when bcd/lz_mask/ovf update.
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     lz_mask;
  logic                  ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, lz_mask, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, lz_mask, ovf
  );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with leading-zero mask and overflow flag.
// Optional saturation to all-9s on overflow when BIN2BCD_SAT_EN is defined.
module bin2bcd_seq #(
  parameter int BIN_W  = disp_pkg::BIN_W,
  parameter int DIGITS = disp_pkg::DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  bin2bcd_seq_if.slave     bus,
  output disp_pkg::state_t state_o
);
  import disp_pkg::state_t;
  import disp_pkg::IDLE;
  import disp_pkg::SHIFT;
  import disp_pkg::pow10_m1;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  lz_q, lz_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_shift;
  logic [BCD_W-1:0]   final_bcd;
  logic [DIGITS-1:0]  final_lz;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (work_q[4*g +: 4]),
      .digit_o (work_adj[4*g +: 4])
    );
  end

  // The carry out of the top digit falls off here, which yields the value mod 10^DIGITS.
  assign work_shift = {work_adj[BCD_W-2:0], bin_q[BIN_W-1]};

`ifdef BIN2BCD_SAT_EN
  assign final_bcd = ovf_pend_q ? {DIGITS{4'h9}} : work_shift;
`else
  assign final_bcd = work_shift;
`endif

  // Bit 0 never blanks, so zero still shows one digit.
  always_comb begin
    logic all_zero;
    final_lz = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero & (final_bcd[4*i +: 4] == 4'd0);
      final_lz[i] = all_zero;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    work_d     = work_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    lz_d       = lz_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d      = bus.bin;
          work_d     = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = (64'(bus.bin) > pow10_m1(DIGITS));
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d = work_shift;
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Results land in one step so the display never sees a partial value.
          bcd_d   = final_bcd;
          lz_d    = final_lz;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      work_q     <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      lz_q       <= LZ_RST;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      lz_q       <= lz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd     = bcd_q;
  assign bus.lz_mask = lz_q;
  assign bus.ovf     = ovf_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: vector table plus reset, back-to-back and start-while-busy sequences.
module tb_bin2bcd_seq;
  import disp_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dut_state;
  int     checks = 0;
  int     errors = 0;

  bin2bcd_seq_if dut_if ();

  bin2bcd_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (dut_if),
    .state_o (dut_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic [7:0]  lz;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns the number of edges until done is seen (-1 on timeout) and busy samples before it.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc    = -1;
    busy_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (dut_if.done) begin
        cyc = n;
        break;
      end
      if (dut_if.busy) busy_n++;
    end
  endtask

  task automatic launch(input logic [26:0] b);
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.bin   = b;
    @(posedge clk);
    #1;
    dut_if.start = 1'b0;
    chk("busy_after_accept", 32'(dut_if.busy), 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] bcd, input logic [7:0] lz, input logic ovf);
    chk({tag, "_bcd"}, dut_if.bcd, bcd);
    chk({tag, "_lz"}, 32'(dut_if.lz_mask), 32'(lz));
    chk({tag, "_ovf"}, 32'(dut_if.ovf), 32'(ovf));
    chk({tag, "_busy"}, 32'(dut_if.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int busy_n;
    int done_cnt;

    vecs[0] = '{27'd12_345_678,  32'h1234_5678, 8'h00, 1'b0};
    vecs[1] = '{27'd0,           32'h0000_0000, 8'hFE, 1'b0};
    vecs[2] = '{27'd405,         32'h0000_0405, 8'hF8, 1'b0};
    vecs[3] = '{27'd99_999_999,  32'h9999_9999, 8'h00, 1'b0};
`ifdef BIN2BCD_SAT_EN
    vecs[4] = '{27'd100_000_000, 32'h9999_9999, 8'h00, 1'b1};
    vecs[5] = '{27'd134_217_727, 32'h9999_9999, 8'h00, 1'b1};
`else
    vecs[4] = '{27'd100_000_000, 32'h0000_0000, 8'hFE, 1'b1};
    vecs[5] = '{27'd134_217_727, 32'h3421_7727, 8'h00, 1'b1};
`endif
    vecs[6] = '{27'd7,           32'h0000_0007, 8'hFE, 1'b0};
    vecs[7] = '{27'd10,          32'h0000_0010, 8'hFC, 1'b0};
    vecs[8] = '{27'd1_000_000,   32'h0100_0000, 8'h80, 1'b0};
    vecs[9] = '{27'd50_000,      32'h0005_0000, 8'hE0, 1'b0};

    dut_if.start = 1'b0;
    dut_if.bin   = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dut_state), 32'(IDLE));
    chk("rst_busy", 32'(dut_if.busy), 32'd0);
    chk("rst_done", 32'(dut_if.done), 32'd0);
    chk("rst_bcd", dut_if.bcd, 32'h0);
    chk("rst_lz", 32'(dut_if.lz_mask), 32'hFE);
    chk("rst_ovf", 32'(dut_if.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single conversions
    for (int v = 0; v < 10; v++) begin
      launch(vecs[v].bin);
      wait_done(cyc, busy_n);
      chk($sformatf("v%0d_latency", v), 32'(cyc), 32'd27);
      chk($sformatf("v%0d_busy_cycles", v), 32'(busy_n), 32'd26);
      chk_result($sformatf("v%0d", v), vecs[v].bcd, vecs[v].lz, vecs[v].ovf);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_width", v), 32'(dut_if.done), 32'd0);
    end

    // start held while busy with bin changed after acceptance, then taken in the done cycle
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.bin   = 27'd12_345_678;
    @(posedge clk);
    #1;
    chk("b2b_busy", 32'(dut_if.busy), 32'd1);
    @(negedge clk);
    dut_if.bin = 27'd405;
    wait_done(cyc, busy_n);
    chk("b2b_first_latency", 32'(cyc), 32'd27);
    chk_result("b2b_first", 32'h1234_5678, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_reaccept_busy", 32'(dut_if.busy), 32'd1);
    chk("b2b_reaccept_done", 32'(dut_if.done), 32'd0);
    @(negedge clk);
    dut_if.start = 1'b0;
    wait_done(cyc, busy_n);
    chk("b2b_second_latency", 32'(cyc), 32'd27);
    chk_result("b2b_second", 32'h0000_0405, 8'hF8, 1'b0);

    // Reset in the middle of a conversion
    launch(27'd99_999_999);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dut_state), 32'(IDLE));
    chk("mid_rst_busy", 32'(dut_if.busy), 32'd0);
    chk("mid_rst_bcd", dut_if.bcd, 32'h0);
    chk("mid_rst_lz", 32'(dut_if.lz_mask), 32'hFE);
    chk("mid_rst_ovf", 32'(dut_if.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (dut_if.done) done_cnt++;
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    chk("mid_rst_idle_bcd", dut_if.bcd, 32'h0);
    launch(27'd87_654_321);
    wait_done(cyc, busy_n);
    chk("post_rst_latency", 32'(cyc), 32'd27);
    chk_result("post_rst", 32'h8765_4321, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
